opb_register_simulink2ppc: RTL and testbench

OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

---
 rtl/opb_s2p_pkg.sv | 21 ++
 rtl/opb_slave_ack.sv | 34 +++
 rtl/opb_register_simulink2ppc.sv | 111 +++++++++++
 tb/tb_opb_register_simulink2ppc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/opb_s2p_pkg.sv
// Shared register map and status layout for the Simulink-to-PPC OPB register cores.
// Byte offsets are relative to C_BASEADDR; status bit positions use LSB-0 numbering.
package opb_s2p_pkg;

    localparam logic [3:0] REG_HOLD_LO   = 4'h0;
    localparam logic [3:0] REG_SHADOW_HI = 4'h4;
    localparam logic [3:0] REG_STATUS    = 4'h8;
    localparam logic [3:0] REG_COUNT     = 4'hC;

    localparam int STAT_NEW_BIT = 31;
    localparam int STAT_OVF_BIT = 30;

    function automatic logic [31:0] status_word(input logic new_flag, input logic ovf);
        logic [31:0] w;
        w               = '0;
        w[STAT_NEW_BIT] = new_flag;
        w[STAT_OVF_BIT] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave address decode and single-pulse transfer acknowledge.
// accept marks the one cycle in which a selected transfer is committed; xfer_ack follows it.
module opb_slave_ack #(
    parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] abus,
    input  logic        select,
    output logic        accept,
    output logic [1:0]  offset,
    output logic        xfer_ack
);

    logic hit;
    logic busy;

    assign hit    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign offset = abus[28:29];
    // busy tracks a hit already accepted, so a held select is acked only once.
    assign accept = hit && !busy && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_ack <= 1'b0;
            busy     <= 1'b0;
        end else begin
            xfer_ack <= accept;
            busy     <= hit;
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// 64-bit fabric-to-PPC register on OPB: hold/shadow pair for coherent reads,
// new/overflow status flags and a free-running capture counter.
module opb_register_simulink2ppc
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    input  logic [63:0]              user_data_in,
    input  logic                     user_we
);

    localparam bit FAMILY_V5 = (C_FAMILY == "virtex5");

    logic        accept;
    logic [1:0]  offset;
    logic [3:0]  byte_off;
    logic        rd;
    logic        wr;
    logic        rd_lo;
    logic        ovf_clr;
    logic [63:0] hold;
    logic [31:0] shadow_hi;
    logic [31:0] cap_count;
    logic        new_flag;
    logic        ovf;
    logic [31:0] rd_data;
    logic        unused_ok;

    opb_slave_ack #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .abus     (OPB_ABus),
        .select   (OPB_select),
        .accept   (accept),
        .offset   (offset),
        .xfer_ack (Sl_xferAck)
    );

    assign byte_off = {offset, 2'b00};
    assign rd       = accept && OPB_RNW;
    assign wr       = accept && !OPB_RNW;
    assign rd_lo    = rd && (byte_off == REG_HOLD_LO);
    // OPB_DBus is big-endian, so value bit n sits at bus index 31-n.
    assign ovf_clr  = wr && (byte_off == REG_STATUS) && OPB_DBus[31-STAT_OVF_BIT];

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = ^{OPB_BE, OPB_seqAddr, OPB_DBus, FAMILY_V5};

    always_comb begin
        rd_data = '0;
        case (byte_off)
            REG_HOLD_LO:   rd_data = hold[31:0];
            REG_SHADOW_HI: rd_data = shadow_hi;
            REG_STATUS:    rd_data = status_word(new_flag, ovf);
            REG_COUNT:     rd_data = cap_count;
            default:       rd_data = '0;
        endcase
    end

    // Reads see pre-edge values, so a capture coinciding with a low-word read
    // returns and latches the old sample; the new one lands in hold afterwards.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            hold      <= '0;
            shadow_hi <= '0;
            cap_count <= '0;
            new_flag  <= 1'b0;
            ovf       <= 1'b0;
            Sl_DBus   <= '0;
        end else begin
            if (user_we) begin
                hold      <= user_data_in;
                cap_count <= cap_count + 32'd1;
            end
            if (rd_lo)
                shadow_hi <= hold[63:32];
            if (user_we)
                new_flag <= 1'b1;
            else if (rd_lo)
                new_flag <= 1'b0;
            if (user_we && new_flag)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            Sl_DBus <= rd ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: reads, coherence, flags, count wrap,
// address window and reset during a transfer.
module tb_opb_register_simulink2ppc;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] HIGH = 32'h0000_01FF;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [63:0] user_data_in;
    logic        user_we;

    int errors = 0;
    int checks = 0;

    opb_register_simulink2ppc #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH)
    ) dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_we      (user_we)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Select held for 'hold' edges, then one more edge sampled after release.
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input logic cap, input logic [63:0] cap_val,
                        output logic [31:0] rdata, output int acks, output int first,
                        output int leaks);
        rdata = '0; acks = 0; first = 0; leaks = 0;
        @(negedge OPB_Clk);
        OPB_select = 1'b1; OPB_ABus = addr; OPB_RNW = rnw;
        OPB_DBus = rnw ? 32'h0 : wdata;
        if (cap) begin user_we = 1'b1; user_data_in = cap_val; end
        for (int i = 1; i <= hold + 1; i++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) begin
                acks++;
                if (first == 0) first = i;
                rdata = Sl_DBus;
            end else if (Sl_DBus != 32'h0) leaks++;
            @(negedge OPB_Clk);
            user_we = 1'b0;
            if (i == hold) begin
                OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_DBus = '0; OPB_ABus = '0;
            end
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d; int a, f, l;
        xfer(1'b1, BASE + 32'(off), 32'h0, 1, 1'b0, 64'h0, d, a, f, l);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_acks"}, 32'(a), 32'd1);
        chk({tag, "_lat"},  32'(f), 32'd1);
        chk({tag, "_idle"}, 32'(l), 32'd0);
    endtask

    task automatic wr(input string tag, input logic [3:0] off, input logic [31:0] val);
        logic [31:0] d; int a, f, l;
        xfer(1'b0, BASE + 32'(off), val, 1, 1'b0, 64'h0, d, a, f, l);
        chk({tag, "_acks"}, 32'(a), 32'd1);
        chk({tag, "_lat"},  32'(f), 32'd1);
        chk({tag, "_dbus"}, d, 32'h0);
    endtask

    task automatic cap(input logic [63:0] v);
        @(negedge OPB_Clk);
        user_we = 1'b1; user_data_in = v;
        @(negedge OPB_Clk);
        user_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d; int a, f, l;
        OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0;
        user_we = 1'b1; user_data_in = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (3) @(posedge OPB_Clk);
        #1;
        chk("rst_ack",  32'(Sl_xferAck), 32'd0);
        chk("rst_dbus", Sl_DBus, 32'h0);
        chk("rst_tie",  32'({Sl_errAck, Sl_retry, Sl_toutSup}), 32'd0);
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0; user_we = 1'b0;
        rd("rst_cnt",  REG_COUNT_OFF(), 32'h0);
        rd("rst_stat", 4'h8, 32'h0);
        rd("rst_lo",   4'h0, 32'h0);

        // basic 64-bit read
        cap(64'h1122_3344_5566_7788);
        rd("basic_lo", 4'h0, 32'h5566_7788);
        rd("basic_hi", 4'h4, 32'h1122_3344);
        rd("basic_cnt", 4'hC, 32'd1);

        // coherence across a capture between the two halves
        cap(64'hAAAA_AAAA_0000_0001);
        rd("coh_lo", 4'h0, 32'h0000_0001);
        cap(64'hBBBB_BBBB_0000_0002);
        rd("coh_hi", 4'h4, 32'hAAAA_AAAA);

        // status flags
        cap(64'h3333_3333_CCCC_CCCC);
        cap(64'h4444_4444_DDDD_DDDD);
        rd("stat_both", 4'h8, 32'hC000_0000);
        wr("stat_w_nop", 4'h8, 32'h8000_0000);
        rd("stat_keep", 4'h8, 32'hC000_0000);
        wr("stat_w_clr", 4'h8, 32'h4000_0000);
        rd("stat_new", 4'h8, 32'h8000_0000);
        rd("stat_rdlo", 4'h0, 32'hDDDD_DDDD);
        rd("stat_zero", 4'h8, 32'h0);

        // writes elsewhere have no effect
        wr("w_lo", 4'h0, 32'hFFFF_FFFF);
        wr("w_cnt", 4'hC, 32'hFFFF_FFFF);
        rd("w_cnt_rb", 4'hC, 32'd5);
        rd("w_stat_rb", 4'h8, 32'h0);

        // capture in the same cycle as a low-word read
        xfer(1'b1, BASE, 32'h0, 1, 1'b1, 64'h5555_AAAA_1234_5678, d, a, f, l);
        chk("coin_data", d, 32'hDDDD_DDDD);
        chk("coin_acks", 32'(a), 32'd1);
        rd("coin_hi",   4'h4, 32'h4444_4444);
        rd("coin_stat", 4'h8, 32'h8000_0000);
        rd("coin_nlo",  4'h0, 32'h1234_5678);
        rd("coin_nhi",  4'h4, 32'h5555_AAAA);

        // address window
        xfer(1'b1, HIGH + 32'd4, 32'h0, 3, 1'b0, 64'h0, d, a, f, l);
        chk("win_hi_acks", 32'(a), 32'd0);
        chk("win_hi_idle", 32'(l), 32'd0);
        xfer(1'b1, BASE - 32'd4, 32'h0, 3, 1'b0, 64'h0, d, a, f, l);
        chk("win_lo_acks", 32'(a), 32'd0);
        chk("win_lo_idle", 32'(l), 32'd0);
        xfer(1'b1, BASE + 32'hC, 32'h0, 3, 1'b0, 64'h0, d, a, f, l);
        chk("win_hit_acks", 32'(a), 32'd1);
        chk("win_hit_lat",  32'(f), 32'd1);
        chk("win_hit_data", d, 32'd6);
        chk("win_hit_idle", 32'(l), 32'd0);

        // count wrap
        @(negedge OPB_Clk);
        force dut.cap_count = 32'hFFFF_FFFF;
        #1 release dut.cap_count;
        rd("wrap_pre", 4'hC, 32'hFFFF_FFFF);
        cap(64'h0);
        rd("wrap_post", 4'hC, 32'h0);

        // reset asserted in the hit cycle of a held read
        cap(64'h7777_8888_9999_AAAA);
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1; OPB_select = 1'b1; OPB_ABus = BASE + 32'hC; OPB_RNW = 1'b1;
        @(posedge OPB_Clk); #1;
        chk("mid_rst_ack",  32'(Sl_xferAck), 32'd0);
        chk("mid_rst_dbus", Sl_DBus, 32'h0);
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        @(posedge OPB_Clk); #1;
        chk("mid_rel_ack", 32'(Sl_xferAck), 32'd1);
        chk("mid_rel_cnt", Sl_DBus, 32'h0);
        @(negedge OPB_Clk);
        OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = '0;
        @(posedge OPB_Clk); #1;
        chk("mid_rel_once", 32'(Sl_xferAck), 32'd0);
        rd("mid_lo",   4'h0, 32'h0);
        rd("mid_hi",   4'h4, 32'h0);
        rd("mid_stat", 4'h8, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [3:0] REG_COUNT_OFF();
        return 4'hC;
    endfunction

endmodule
